// File: rtl/clip_pkg.sv
// Shared types and helpers for the clip monitor.
package clip_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned ABS_WIDTH = 32;

    // |x| of a sign-extended sample, saturated to 2^(dw-1)-1; callers keep the low dw-1 bits.
    function automatic logic [ABS_WIDTH-1:0] abs_sat(input logic signed [ABS_WIDTH-1:0] x,
                                                     input int unsigned dw);
        logic signed [ABS_WIDTH:0] xe;
        logic [ABS_WIDTH:0]        mag;
        logic [ABS_WIDTH:0]        lim;
        xe  = {x[ABS_WIDTH-1], x};
        mag = xe[ABS_WIDTH] ? (ABS_WIDTH+1)'(-xe) : (ABS_WIDTH+1)'(xe);
        lim = ((ABS_WIDTH+1)'(1) << (dw - 1)) - (ABS_WIDTH+1)'(1);
        return (mag > lim) ? lim[ABS_WIDTH-1:0] : mag[ABS_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/clip_window_acc.sv
// Per-window sample counter, saturating clip accumulator and peak tracker.
module clip_window_acc #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned WINDOW_WIDTH = 16,
    parameter int unsigned COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    clear,
    input  logic                    sample_en,
    input  logic                    clip,
    input  logic [DATA_WIDTH-2:0]   mag,
    input  logic [WINDOW_WIDTH-1:0] len,
    output logic                    eow_c,
    output logic [COUNT_WIDTH-1:0]  clip_count,
    output logic [DATA_WIDTH-2:0]   peak,
    output logic                    stats_valid
);

    localparam int unsigned MAG_WIDTH = DATA_WIDTH - 1;

    logic [WINDOW_WIDTH-1:0] cnt;
    logic [COUNT_WIDTH-1:0]  acc;
    logic [MAG_WIDTH-1:0]    peak_acc;
    logic [COUNT_WIDTH-1:0]  acc_next;
    logic [MAG_WIDTH-1:0]    peak_next;

    // Totals including the current sample.
    always_comb begin
        acc_next  = acc;
        peak_next = peak_acc;
        if (clip && (acc != '1)) begin
            acc_next = acc + COUNT_WIDTH'(1);
        end
        if (mag > peak_acc) begin
            peak_next = mag;
        end
    end

    assign eow_c = sample_en && (cnt == len - WINDOW_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt         <= '0;
            acc         <= '0;
            peak_acc    <= '0;
            clip_count  <= '0;
            peak        <= '0;
            stats_valid <= 1'b0;
        end else begin
            stats_valid <= 1'b0;
            if (clear) begin
                cnt      <= '0;
                acc      <= '0;
                peak_acc <= '0;
            end else if (sample_en) begin
                if (eow_c) begin
                    clip_count  <= acc_next;
                    peak        <= peak_next;
                    stats_valid <= 1'b1;
                    cnt         <= '0;
                    acc         <= '0;
                    peak_acc    <= '0;
                end else begin
                    cnt      <= cnt + WINDOW_WIDTH'(1);
                    acc      <= acc_next;
                    peak_acc <= peak_next;
                end
            end
        end
    end

endmodule

// File: rtl/clip_monitor.sv
// Clip detector on the saturated sample stream with windowed statistics and sticky flags.
module clip_monitor
    import clip_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned MAX_VAL      = 15,
    parameter int unsigned WINDOW_WIDTH = 16,
    parameter int unsigned COUNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic signed [DATA_WIDTH-1:0] din,
    input  logic                         din_valid,
    input  logic [WINDOW_WIDTH-1:0]      window_len,
    input  logic                         clear,
    output logic signed [DATA_WIDTH-1:0] dout,
    output logic                         dout_valid,
    output logic                         pos_clip,
    output logic                         neg_clip,
    output logic [COUNT_WIDTH-1:0]       clip_count,
    output logic [DATA_WIDTH-2:0]        peak,
    output logic                         stats_valid,
    output logic                         sticky_pos,
    output logic                         sticky_neg
);

    localparam int unsigned MAG_WIDTH = DATA_WIDTH - 1;
    localparam logic signed [DATA_WIDTH-1:0] POS_LIM = DATA_WIDTH'(MAX_VAL);
    localparam logic signed [DATA_WIDTH-1:0] NEG_LIM = -POS_LIM;

    state_t                  state;
    logic [WINDOW_WIDTH-1:0] len_q;
    logic                    pos_c;
    logic                    neg_c;
    logic                    sample_en_c;
    logic                    eow_c;
    logic [MAG_WIDTH-1:0]    mag_c;

    assign pos_c       = din_valid && (din >= POS_LIM);
    assign neg_c       = din_valid && (din <= NEG_LIM);
    assign mag_c       = MAG_WIDTH'(abs_sat(ABS_WIDTH'(din), DATA_WIDTH));
    assign sample_en_c = din_valid && (state == RUN) && !clear;

    // Pass-through and sticky flags; a sample taken with clear never sets a sticky flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            pos_clip   <= 1'b0;
            neg_clip   <= 1'b0;
            sticky_pos <= 1'b0;
            sticky_neg <= 1'b0;
        end else begin
            dout       <= din;
            dout_valid <= din_valid;
            pos_clip   <= pos_c;
            neg_clip   <= neg_c;
            if (clear) begin
                sticky_pos <= 1'b0;
                sticky_neg <= 1'b0;
            end else begin
                sticky_pos <= sticky_pos | pos_c;
                sticky_neg <= sticky_neg | neg_c;
            end
        end
    end

    // Window length only changes on clear, leaving IDLE, or at a window boundary.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            len_q <= '0;
        end else if (clear) begin
            len_q <= window_len;
            state <= (window_len != '0) ? RUN : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (window_len != '0) begin
                        len_q <= window_len;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (eow_c) begin
                        len_q <= window_len;
                        state <= (window_len != '0) ? RUN : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    clip_window_acc #(
        .DATA_WIDTH   (DATA_WIDTH),
        .WINDOW_WIDTH (WINDOW_WIDTH),
        .COUNT_WIDTH  (COUNT_WIDTH)
    ) u_acc (
        .clk         (clk),
        .resetn      (resetn),
        .clear       (clear),
        .sample_en   (sample_en_c),
        .clip        (pos_c || neg_c),
        .mag         (mag_c),
        .len         (len_q),
        .eow_c       (eow_c),
        .clip_count  (clip_count),
        .peak        (peak),
        .stats_valid (stats_valid)
    );

endmodule
